// File: rtl/rs_sched_pkg.sv
// ----------------------------------------------------------------------------
// rs_sched_pkg
//   Shared constants, types and helpers for the reservation-station age
//   scheduler (rs_age_scheduler) and its oldest-entry picker.
//   RS_SIZE   : number of RS entries (>= 2)
//   RS_IDX_W  : entry index width
//   rs_mat_t  : age matrix, m[i][j] = 1 means entry i is older than entry j
// ----------------------------------------------------------------------------
package rs_sched_pkg;

    localparam int RS_SIZE  = 4;
    localparam int RS_IDX_W = $clog2(RS_SIZE);

    typedef logic [RS_IDX_W-1:0]             rs_idx_t;
    typedef logic [RS_SIZE-1:0]              rs_vec_t;
    typedef logic [RS_IDX_W:0]               rs_cnt_t;
    typedef logic [RS_SIZE-1:0][RS_SIZE-1:0] rs_mat_t;

    function automatic rs_cnt_t popcount(input rs_vec_t v);
        rs_cnt_t n;
        n = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            n = n + rs_cnt_t'(v[i]);
        end
        return n;
    endfunction

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic rs_idx_t lowest_idx(input rs_vec_t v);
        rs_idx_t r;
        r = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (v[i]) r = rs_idx_t'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_oldest_select.sv
// ----------------------------------------------------------------------------
// rs_oldest_select
//   Combinational picker: selects the candidate that no other candidate is
//   older than.
//   cand_i    in   candidate vector
//   older_i   in   age matrix (older_i[j][i] = j older than i)
//   sel_oh_o  out  one-hot of the oldest candidate (zero if none)
//   sel_idx_o out  index of the oldest candidate (0 if none)
// ----------------------------------------------------------------------------
module rs_oldest_select
    import rs_sched_pkg::*;
(
    input  logic [RS_SIZE-1:0]              cand_i,
    input  logic [RS_SIZE-1:0][RS_SIZE-1:0] older_i,
    output logic [RS_SIZE-1:0]              sel_oh_o,
    output logic [RS_IDX_W-1:0]             sel_idx_o
);

    rs_vec_t blocked;

    always_comb begin
        blocked  = '0;
        sel_oh_o = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            // Entry i is blocked by any candidate j that is older than it.
            for (int j = 0; j < RS_SIZE; j++) begin
                blocked[i] = blocked[i] | (cand_i[j] & older_i[j][i]);
            end
            sel_oh_o[i] = cand_i[i] & ~blocked[i];
        end
        sel_idx_o = lowest_idx(sel_oh_o);
    end

endmodule

// File: rtl/rs_age_scheduler.sv
// ----------------------------------------------------------------------------
// rs_age_scheduler
//   Issue scheduler for an RS_SIZE-entry reservation station. Tracks
//   occupancy and relative age, grants dispatch the lowest free slot and
//   offers the oldest operand-ready entry to one FU over valid/ready.
//   An offer that stalls is locked so the FU sees a stable index.
// Ports
//   clk_i, reset_ni      clock / async active-low reset
//   flush_i              squash everything; blocks alloc and issue this cycle
//   alloc_valid_i/_ready_o/_idx_o   dispatch handshake and granted slot
//   entry_ready_i        per-entry operands ready
//   issue_valid_o/_ready_i/_idx_o/_onehot_o  FU issue handshake
//   entry_valid_o, count_o           occupancy vector and popcount
//   stall_cnt_o          (RS_SCHED_STALL_CNT_EN only) saturating stall count
// Configuration
//   RS_SCHED_STALL_CNT_EN : adds stall_cnt_o and its counter.
// ----------------------------------------------------------------------------
module rs_age_scheduler
    import rs_sched_pkg::*;
(
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                flush_i,
    input  logic                alloc_valid_i,
    output logic                alloc_ready_o,
    output logic [RS_IDX_W-1:0] alloc_idx_o,
    input  logic [RS_SIZE-1:0]  entry_ready_i,
    output logic                issue_valid_o,
    input  logic                issue_ready_i,
    output logic [RS_IDX_W-1:0] issue_idx_o,
    output logic [RS_SIZE-1:0]  issue_onehot_o,
    output logic [RS_SIZE-1:0]  entry_valid_o,
    output logic [RS_IDX_W:0]   count_o
`ifdef RS_SCHED_STALL_CNT_EN
   ,output logic [15:0]         stall_cnt_o
`endif
);

    rs_vec_t valid_q, valid_d;
    rs_mat_t older_q, older_d;
    logic    lock_q, lock_d;
    rs_idx_t lock_idx_q, lock_idx_d;

    rs_vec_t cand;
    rs_vec_t sel_oh;
    rs_idx_t sel_idx;
    logic    issue_fire;
    logic    alloc_fire;

    rs_oldest_select u_sel (
        .cand_i    (cand),
        .older_i   (older_q),
        .sel_oh_o  (sel_oh),
        .sel_idx_o (sel_idx)
    );

    // Outputs are purely from registered state plus this cycle's inputs.
    always_comb begin
        alloc_ready_o  = |(~valid_q);
        alloc_idx_o    = lowest_idx(~valid_q);
        cand           = valid_q & entry_ready_i;
        issue_idx_o    = lock_q ? lock_idx_q : sel_idx;
        issue_valid_o  = (lock_q | (|cand)) & ~flush_i;
        issue_onehot_o = issue_valid_o ? (rs_vec_t'(1) << issue_idx_o) : '0;
        issue_fire     = issue_valid_o & issue_ready_i;
        alloc_fire     = alloc_valid_i & alloc_ready_o & ~flush_i;
        entry_valid_o  = valid_q;
        count_o        = popcount(valid_q);
    end

    always_comb begin
        valid_d    = valid_q;
        older_d    = older_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (flush_i) begin
            valid_d = '0;
            older_d = '0;
            lock_d  = 1'b0;
        end else begin
            if (issue_fire) begin
                valid_d[issue_idx_o] = 1'b0;
                lock_d               = 1'b0;
            end else if (issue_valid_o) begin
                // Stalled offer: pin it until the FU takes it.
                lock_d     = 1'b1;
                lock_idx_d = issue_idx_o;
            end
            if (alloc_fire) begin
                // The slot is free in registered state, so it can never be
                // the slot issuing this cycle. The new entry is younger than
                // every survivor; an entry leaving this cycle does not count.
                valid_d[alloc_idx_o] = 1'b1;
                older_d[alloc_idx_o] = '0;
                for (int j = 0; j < RS_SIZE; j++) begin
                    older_d[j][alloc_idx_o] = valid_q[j] &
                        ~(issue_fire && (issue_idx_o == rs_idx_t'(j)));
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_q    <= '0;
            older_q    <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            valid_q    <= valid_d;
            older_q    <= older_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

`ifdef RS_SCHED_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating; deliberately survives flush.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (issue_valid_o && !issue_ready_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) stall_cnt_q <= '0;
        else           stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
